mem_bus_arbiter: RTL and testbench

- Shares one single-port memory slave between the CPU instruction-fetch master and the CPU data master.
- Sits between the MIPS core and the unified RAM. All three ports use the Avalon-style address/read/write/waitrequest handshake.
- Arbitration is round-robin under contention. A watchdog aborts a slave transfer that stalls too long and raises a sticky error flag.

---
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin arbiter sharing one Avalon-style memory slave between
//            the instruction-fetch and data masters, with a stall watchdog.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic                  i_read,
    output logic                  i_waitrequest,
    output logic [DATA_W-1:0]     i_readdata,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [DATA_W-1:0]     d_writedata,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    output logic                  d_waitrequest,
    output logic [DATA_W-1:0]     d_readdata,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic [DATA_W/8-1:0]   m_byteenable,
    input  logic                  m_waitrequest,
    input  logic [DATA_W-1:0]     m_readdata,
    output logic                  bus_error
);

    localparam int          c_BE_W         = DATA_W / 8;
    localparam logic        c_PTR_I        = 1'b0;
    localparam logic        c_PTR_D        = 1'b1;
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr_ptr;
    logic [15:0] r_watchdog;
    logic        r_bus_error;

    logic w_i_req;
    logic w_d_req;
    logic w_granted_req;

    assign w_i_req       = i_read;
    assign w_d_req       = d_read | d_write;
    assign w_granted_req = (r_state == GRANT_I) ? w_i_req :
                           (r_state == GRANT_D) ? w_d_req : 1'b0;
    assign bus_error     = r_bus_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= c_PTR_I;
            r_watchdog  <= 16'd0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_watchdog <= 16'd0;
                    if (w_i_req && w_d_req)
                        r_state <= (r_rr_ptr == c_PTR_I) ? GRANT_I : GRANT_D;
                    else if (w_i_req)
                        r_state <= GRANT_I;
                    else if (w_d_req)
                        r_state <= GRANT_D;
                end
                GRANT_I, GRANT_D: begin
                    if (!w_granted_req) begin
                        // Master withdrew: no completion, fairness pointer untouched.
                        r_state    <= IDLE;
                        r_watchdog <= 16'd0;
                    end else if (!m_waitrequest) begin
                        r_state    <= IDLE;
                        r_rr_ptr   <= (r_state == GRANT_I) ? c_PTR_D : c_PTR_I;
                        r_watchdog <= 16'd0;
                    end else if (r_watchdog == c_TIMEOUT_LAST) begin
                        r_state     <= IDLE;
                        r_rr_ptr    <= ~r_rr_ptr;
                        r_watchdog  <= 16'd0;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_watchdog <= r_watchdog + 16'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_watchdog <= 16'd0;
                end
            endcase
        end
    end

    always_comb begin
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = '0;
        d_readdata    = '0;
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        case (r_state)
            GRANT_I: begin
                m_address     = i_address;
                m_read        = i_read;
                m_byteenable  = {c_BE_W{1'b1}};
                i_waitrequest = m_waitrequest;
                i_readdata    = m_readdata;
            end
            GRANT_D: begin
                m_address     = d_address;
                m_write       = d_write;
                m_read        = d_read & ~d_write;
                m_writedata   = d_writedata;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest;
                d_readdata    = m_readdata;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Cycle-by-cycle vector table with scoreboard queue plus hand-written
//            reset-in-transfer sequence for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        bus_error;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_waitrequest (i_waitrequest),
        .i_readdata    (i_readdata),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .bus_error     (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        mwt;
        logic [31:0] mrd;
        logic        e_iw;
        logic        e_dw;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_ma;
        logic [3:0]  e_mbe;
        logic [31:0] e_mwd;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
        input logic mwt, input logic [31:0] mrd,
        input logic e_iw, input logic e_dw, input logic e_mr, input logic e_mw,
        input logic [31:0] e_ma, input logic [3:0] e_mbe, input logic [31:0] e_mwd,
        input logic [31:0] e_ird, input logic [31:0] e_drd, input logic e_err);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.dbe = dbe; v.mwt = mwt; v.mrd = mrd;
        v.e_iw = e_iw; v.e_dw = e_dw; v.e_mr = e_mr; v.e_mw = e_mw;
        v.e_ma = e_ma; v.e_mbe = e_mbe; v.e_mwd = e_mwd;
        v.e_ird = e_ird; v.e_drd = e_drd; v.e_err = e_err;
        return v;
    endfunction

    // Arbiter idle: both masters stalled, slave bus fully quiet.
    function automatic vec_t idl(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
        input logic mwt, input logic [31:0] mrd, input logic e_err);
        return mk(ir, ia, dr, dw, da, dwd, dbe, mwt, mrd,
                  1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, e_err);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        i_read        = v.ir;
        i_address     = v.ia;
        d_read        = v.dr;
        d_write       = v.dw;
        d_address     = v.da;
        d_writedata   = v.dwd;
        d_byteenable  = v.dbe;
        m_waitrequest = v.mwt;
        m_readdata    = v.mrd;
    endtask

    task automatic compare(input int k, input vec_t v);
        check($sformatf("row%0d i_waitrequest", k), 32'(i_waitrequest), 32'(v.e_iw));
        check($sformatf("row%0d d_waitrequest", k), 32'(d_waitrequest), 32'(v.e_dw));
        check($sformatf("row%0d m_read", k),        32'(m_read),        32'(v.e_mr));
        check($sformatf("row%0d m_write", k),       32'(m_write),       32'(v.e_mw));
        check($sformatf("row%0d m_address", k),     m_address,          v.e_ma);
        check($sformatf("row%0d m_byteenable", k),  32'(m_byteenable),  32'(v.e_mbe));
        check($sformatf("row%0d m_writedata", k),   m_writedata,        v.e_mwd);
        check($sformatf("row%0d i_readdata", k),    i_readdata,         v.e_ird);
        check($sformatf("row%0d d_readdata", k),    d_readdata,         v.e_drd);
        check($sformatf("row%0d bus_error", k),     32'(bus_error),     32'(v.e_err));
    endtask

    initial begin
        vec_t v;

        // Contention from reset: I, D, I with an idle bubble between grants.
        tbl.push_back(idl(1, 32'h100, 1, 0, 32'h200, 0, 4'hF, 0, 32'hAAAA0001, 0));
        tbl.push_back(mk (1, 32'h100, 1, 0, 32'h200, 0, 4'hF, 0, 32'hAAAA0001, 0, 1, 1, 0, 32'h100, 4'hF, 0, 32'hAAAA0001, 0, 0));
        tbl.push_back(idl(1, 32'h100, 1, 0, 32'h200, 0, 4'hF, 0, 32'hAAAA0001, 0));
        tbl.push_back(mk (1, 32'h100, 1, 0, 32'h200, 0, 4'hF, 0, 32'hAAAA0001, 1, 0, 1, 0, 32'h200, 4'hF, 0, 0, 32'hAAAA0001, 0));
        tbl.push_back(idl(1, 32'h100, 1, 0, 32'h200, 0, 4'hF, 0, 32'hAAAA0001, 0));
        tbl.push_back(mk (1, 32'h100, 1, 0, 32'h200, 0, 4'hF, 0, 32'hAAAA0001, 0, 1, 1, 0, 32'h100, 4'hF, 0, 32'hAAAA0001, 0, 0));
        tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Lone instruction fetch, zero-wait slave.
        tbl.push_back(idl(1, 32'h4, 0, 0, 0, 0, 0, 0, 32'h8C020000, 0));
        tbl.push_back(mk (1, 32'h4, 0, 0, 0, 0, 0, 0, 32'h8C020000, 0, 1, 1, 0, 32'h4, 4'hF, 0, 32'h8C020000, 0, 0));
        tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Read and write together: write wins, byte lanes passed through.
        tbl.push_back(idl(0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h5555, 0));
        tbl.push_back(mk (0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'h3, 0, 32'h5555, 1, 0, 0, 1, 32'h1000, 4'h3, 32'hDEADBEEF, 0, 32'h5555, 0));
        tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Data read with three slave wait states (below the timeout).
        tbl.push_back(idl(0, 0, 1, 0, 32'h2000, 0, 4'hF, 1, 32'h11111111, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 1, 0, 32'h2000, 0, 4'hF, 1, 32'h11111111, 1, 1, 1, 0, 32'h2000, 4'hF, 0, 0, 32'h11111111, 0));
        tbl.push_back(mk (0, 0, 1, 0, 32'h2000, 0, 4'hF, 0, 32'h11111111, 1, 0, 1, 0, 32'h2000, 4'hF, 0, 0, 32'h11111111, 0));
        tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Stuck slave on an instruction grant: abort after 4 stalls, then data is served.
        tbl.push_back(idl(1, 32'h300, 1, 0, 32'h400, 0, 4'hF, 1, 32'h77, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 32'h300, 1, 0, 32'h400, 0, 4'hF, 1, 32'h77, 1, 1, 1, 0, 32'h300, 4'hF, 0, 32'h77, 0, 0));
        tbl.push_back(idl(1, 32'h300, 1, 0, 32'h400, 0, 4'hF, 1, 32'h77, 1));
        tbl.push_back(mk (1, 32'h300, 1, 0, 32'h400, 0, 4'hF, 0, 32'h77, 1, 0, 1, 0, 32'h400, 4'hF, 0, 0, 32'h77, 1));
        tbl.push_back(idl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Fetch so that the pointer favours data before the reset sequence.
        tbl.push_back(idl(1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk (1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h8, 4'hF, 0, 0, 0, 1));

        reset_n = 1'b0;
        apply(idl(1, 32'h10, 0, 1, 32'h20, 32'h1, 4'hF, 0, 32'h99, 0));
        @(negedge clk);
        check("reset i_waitrequest", 32'(i_waitrequest), 32'd1);
        check("reset d_waitrequest", 32'(d_waitrequest), 32'd1);
        check("reset m_read",        32'(m_read),        32'd0);
        check("reset m_write",       32'(m_write),       32'd0);
        check("reset bus_error",     32'(bus_error),     32'd0);
        apply(idl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            apply(tbl[k]);
            expq.push_back(tbl[k]);
            @(negedge clk);
            v = expq.pop_front();
            compare(k, v);
        end

        // Asynchronous reset in the middle of a data write.
        @(posedge clk);
        #1;
        apply(idl(0, 0, 0, 1, 32'h500, 32'h12345678, 4'hF, 1, 0, 0));
        @(negedge clk);
        check("pre-grant m_write", 32'(m_write), 32'd0);
        @(posedge clk);
        #1;
        check("grant_d m_write",   32'(m_write),   32'd1);
        check("grant_d m_address", m_address,      32'h500);
        #2;
        reset_n = 1'b0;
        #1;
        check("async m_write",       32'(m_write),       32'd0);
        check("async m_address",     m_address,          32'h0);
        check("async d_waitrequest", 32'(d_waitrequest), 32'd1);
        check("async bus_error",     32'(bus_error),     32'd0);
        apply(idl(1, 32'hC, 1, 0, 32'h600, 0, 4'hF, 0, 32'h3C, 0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset m_read",        32'(m_read),        32'd1);
        check("post-reset m_address",     m_address,          32'hC);
        check("post-reset i_waitrequest", 32'(i_waitrequest), 32'd0);
        check("post-reset i_readdata",    i_readdata,         32'h3C);
        check("post-reset d_waitrequest", 32'(d_waitrequest), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
